// File: rtl/dec_scan_n.sv
// dec_scan_n: registered N-to-2^N one-hot decoder with direct decode,
// free-running up/down scan and a start-triggered one-shot sweep.
// All outputs come straight from flops so select lines never glitch.
module dec_scan_n #(
    parameter int N   = 3,
    parameter int DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [N-1:0]     in,
    input  logic             start,
    output logic [2**N-1:0]  out,
    output logic [N-1:0]     idx,
    output logic             busy,
    output logic             wrap
);

    localparam int W  = 2**N;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [N-1:0]  IDX_LAST = '1;

    typedef enum logic {IDLE, RUN} sweep_t;

    sweep_t          state, state_nxt;
    logic [1:0]      mode_prev;
    logic [PW-1:0]   pre, pre_nxt;
    logic [N-1:0]    idx_nxt;
    logic [W-1:0]    out_nxt;
    logic            wrap_nxt;
    logic            changed;
    logic            last_dwell;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] v);
        onehot = W'(1) << v;
    endfunction

    assign busy = (state == RUN);

    // Next-state decode: mode-change handling first, then per-mode behaviour.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        pre_nxt    = pre;
        out_nxt    = '0;
        wrap_nxt   = 1'b0;
        changed    = (mode != mode_prev);
        last_dwell = (pre == PRE_LAST);
        if (en) begin
            if (changed) begin
                // A fresh mode always starts a full dwell; any sweep is abandoned
                // and start is not honoured on this edge.
                pre_nxt   = '0;
                state_nxt = IDLE;
                unique case (mode)
                    2'b00: begin
                        idx_nxt = in;
                        out_nxt = onehot(in);
                    end
                    2'b01, 2'b10: out_nxt = onehot(idx);
                    default:      out_nxt = '0;
                endcase
            end else begin
                unique case (mode)
                    2'b00: begin
                        idx_nxt = in;
                        out_nxt = onehot(in);
                        pre_nxt = '0;
                    end
                    2'b01: begin
                        if (last_dwell) begin
                            pre_nxt  = '0;
                            idx_nxt  = idx + 1'b1;
                            wrap_nxt = (idx == IDX_LAST);
                        end else begin
                            pre_nxt = pre + 1'b1;
                        end
                        out_nxt = onehot(idx_nxt);
                    end
                    2'b10: begin
                        if (last_dwell) begin
                            pre_nxt  = '0;
                            idx_nxt  = idx - 1'b1;
                            wrap_nxt = (idx == '0);
                        end else begin
                            pre_nxt = pre + 1'b1;
                        end
                        out_nxt = onehot(idx_nxt);
                    end
                    default: begin
                        if (state == IDLE) begin
                            if (start) begin
                                idx_nxt   = '0;
                                pre_nxt   = '0;
                                state_nxt = RUN;
                                out_nxt   = onehot('0);
                            end
                        end else if (last_dwell) begin
                            pre_nxt = '0;
                            if (idx == IDX_LAST) begin
                                // Sweep complete: release the selects and flag it.
                                state_nxt = IDLE;
                                idx_nxt   = '0;
                                wrap_nxt  = 1'b1;
                            end else begin
                                idx_nxt = idx + 1'b1;
                                out_nxt = onehot(idx_nxt);
                            end
                        end else begin
                            pre_nxt = pre + 1'b1;
                            out_nxt = onehot(idx);
                        end
                    end
                endcase
            end
        end
    end

    // State and output registers; with en low the comb defaults hold all state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            pre       <= '0;
            out       <= '0;
            wrap      <= 1'b0;
            mode_prev <= 2'b00;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            pre   <= pre_nxt;
            out   <= out_nxt;
            wrap  <= wrap_nxt;
            if (en) mode_prev <= mode;
        end
    end

endmodule

// File: tb/tb_dec_scan_n.sv
// Directed bench for dec_scan_n: a vector table for direct decode plus
// hand-written sequences for scan, en gaps, sweep, mode change and reset.
module tb_dec_scan_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [2:0] in;
    logic       start;
    logic [7:0] out;
    logic [2:0] idx;
    logic       busy;
    logic       wrap;

    logic       en1;
    logic [1:0] mode1;
    logic [1:0] in1;
    logic       start1;
    logic [3:0] out1;
    logic [1:0] idx1;
    logic       busy1;
    logic       wrap1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [2:0] in;
        logic       start;
        logic [7:0] e_out;
        logic [2:0] e_idx;
        logic       e_busy;
        logic       e_wrap;
    } vec_t;

    vec_t vecs[$];

    dec_scan_n #(.N(3), .DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in), .start(start),
        .out(out), .idx(idx), .busy(busy), .wrap(wrap)
    );

    dec_scan_n #(.N(2), .DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .in(in1), .start(start1),
        .out(out1), .idx(idx1), .busy(busy1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] e_out, input logic [2:0] e_idx,
                           input logic e_busy, input logic e_wrap);
        chk({name, ".out"},  {24'd0, out},  {24'd0, e_out});
        chk({name, ".idx"},  {29'd0, idx},  {29'd0, e_idx});
        chk({name, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({name, ".wrap"}, {31'd0, wrap}, {31'd0, e_wrap});
    endtask

    function automatic vec_t mk(input logic e, input logic [1:0] m, input logic [2:0] i,
                                input logic s, input logic [7:0] eo, input logic [2:0] ei,
                                input logic eb, input logic ew);
        vec_t v;
        v.en = e; v.mode = m; v.in = i; v.start = s;
        v.e_out = eo; v.e_idx = ei; v.e_busy = eb; v.e_wrap = ew;
        return v;
    endfunction

    initial begin
        logic [7:0] dout1 [6];
        logic [1:0] didx1 [6];
        logic       dwrp1 [6];
        int p;

        // Direct-mode vectors: each select held two cycles, then en gap, then resume.
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1'b1, 2'b00, 3'(i), 1'b0, 8'(1 << i), 3'(i), 1'b0, 1'b0));
            vecs.push_back(mk(1'b1, 2'b00, 3'(i), 1'b0, 8'(1 << i), 3'(i), 1'b0, 1'b0));
        end
        vecs.push_back(mk(1'b0, 2'b00, 3'd2, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b00, 3'd2, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'b00, 3'd5, 1'b0, 8'h20, 3'd5, 1'b0, 1'b0));

        dout1 = '{8'h1, 8'h2, 8'h4, 8'h8, 8'h1, 8'h2};
        didx1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        dwrp1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; en = 1'b0; mode = 2'b00; in = '0; start = 1'b0;
        en1 = 1'b0; mode1 = 2'b01; in1 = '0; start1 = 1'b0;
        tick; tick;
        chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Table-driven direct decode
        foreach (vecs[i]) begin
            en = vecs[i].en; mode = vecs[i].mode; in = vecs[i].in; start = vecs[i].start;
            tick;
            chk_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_idx, vecs[i].e_busy, vecs[i].e_wrap);
        end

        // DIV=1 instance: steps every enabled cycle, wraps 3 -> 0
        en1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk($sformatf("div1.out%0d", k), {28'd0, out1}, {24'd0, dout1[k]});
            chk($sformatf("div1.idx%0d", k), {30'd0, idx1}, {30'd0, didx1[k]});
            chk($sformatf("div1.wrap%0d", k), {31'd0, wrap1}, {31'd0, dwrp1[k]});
        end
        en1 = 1'b0;
        tick;
        chk("div1.off", {27'd0, busy1, out1}, 32'd0);

        // Scan up from idx 0 for 40 cycles: 4-cycle dwell, wrap on 0x80 -> 0x01
        in = 3'd0;
        tick;
        chk_all("pre_up", 8'h01, 3'd0, 1'b0, 1'b0);
        mode = 2'b01;
        for (int k = 1; k <= 40; k++) begin
            tick;
            p = ((k - 1) / 4) % 8;
            chk_all($sformatf("up%0d", k), 8'(1 << p), 3'(p), 1'b0, k == 33);
        end

        // Mode change mid-scan at pre=2, then back to scan with a full dwell
        mode = 2'b00; in = 3'd0;
        tick;
        chk_all("mc_dir0", 8'h01, 3'd0, 1'b0, 1'b0);
        mode = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk_all($sformatf("mc_up%0d", k), 8'h01, 3'd0, 1'b0, 1'b0);
        end
        mode = 2'b00; in = 3'd3;
        tick;
        chk_all("mc_dir3", 8'h08, 3'd3, 1'b0, 1'b0);
        mode = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            tick;
            if (k < 5) chk_all($sformatf("mc_back%0d", k), 8'h08, 3'd3, 1'b0, 1'b0);
            else       chk_all("mc_back5", 8'h10, 3'd4, 1'b0, 1'b0);
        end

        // Scan down from idx 5, en gap of 3 cycles, no lost dwell, wrap on 0 -> 7
        mode = 2'b00; in = 3'd5;
        tick;
        chk_all("dn_dir5", 8'h20, 3'd5, 1'b0, 1'b0);
        mode = 2'b10;
        for (int k = 1; k <= 6; k++) begin
            tick;
            if (k < 5) chk_all($sformatf("dn%0d", k), 8'h20, 3'd5, 1'b0, 1'b0);
            else       chk_all($sformatf("dn%0d", k), 8'h10, 3'd4, 1'b0, 1'b0);
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk_all($sformatf("dn_gap%0d", k), 8'h00, 3'd4, 1'b0, 1'b0);
        end
        en = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            tick;
            p = (4 - ((j + 1) / 4) + 8) % 8;
            chk_all($sformatf("dn_re%0d", j), 8'(1 << p), 3'(p), 1'b0, j == 19);
        end

        // Sweep: start on the mode-change edge is ignored
        mode = 2'b11; start = 1'b1;
        tick;
        chk_all("sw_change", 8'h00, 3'd7, 1'b0, 1'b0);
        tick;
        chk_all("sw_t0", 8'h01, 3'd0, 1'b1, 1'b0);
        for (int t = 1; t <= 33; t++) begin
            start = (t == 10);
            tick;
            if (t < 32)       chk_all($sformatf("sw_t%0d", t), 8'(1 << (t / 4)), 3'(t / 4), 1'b1, 1'b0);
            else if (t == 32) chk_all("sw_end", 8'h00, 3'd0, 1'b0, 1'b1);
            else              chk_all("sw_after", 8'h00, 3'd0, 1'b0, 1'b0);
        end
        start = 1'b0;

        // Async reset mid-sweep at idx 4
        start = 1'b1;
        tick;
        chk_all("rs_t0", 8'h01, 3'd0, 1'b1, 1'b0);
        start = 1'b0;
        for (int t = 1; t <= 16; t++) tick;
        chk_all("rs_t16", 8'h10, 3'd4, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("rs_async", 8'h00, 3'd0, 1'b0, 1'b0);
        tick;
        tick;
        chk_all("rs_hold", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick;
        chk_all("rs_release", 8'h00, 3'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
